// File: rtl/iter_alu.sv
// Handshaked ALU: one-cycle logic/arith ops, iterative 1-bit/cycle rotates.
// Define ITER_ALU_FAST_ROT_EN to replace the iterative rotator with a one-cycle barrel rotator.
module iter_alu #(
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [4:0]       Selector,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] O,
   output logic             cout,
   output logic             bad_op
);

   typedef enum logic [1:0] {IDLE = 2'd0, ROT = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   logic [WIDTH-1:0] res;
   logic             res_cout;
   logic             res_bad;
   logic [AW-1:0]    amt;

   assign amt      = I1[AW-1:0];
   assign in_ready = (state == IDLE) && !reset;

`ifndef ITER_ALU_FAST_ROT_EN
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_nxt;
   logic [AW-1:0]    cnt;
   logic             dir_left;
   logic             is_rot;
   logic             rot_left;

   assign work_nxt = dir_left ? {work[WIDTH-2:0], work[WIDTH-1]}
                              : {work[0], work[WIDTH-1:1]};
`endif

   always_comb begin
      res      = '0;
      res_cout = 1'b0;
      res_bad  = 1'b0;
`ifndef ITER_ALU_FAST_ROT_EN
      is_rot   = 1'b0;
      rot_left = 1'b0;
`endif
      case (Selector)
         5'b10000:          {res_cout, res} = {1'b0, I1} + {1'b0, I2};
         5'b10011, 5'b00111: res = ~(I1 | I2);
         5'b00010:          res = ~I2;
         5'b01000:          res = {{(WIDTH-1){1'b0}}, (I1 <= I2)};
`ifdef ITER_ALU_FAST_ROT_EN
         // shifting by WIDTH yields zero, so amount 0 still returns I2
         5'b00000:          res = (I2 << amt) | (I2 >> (WIDTH - int'(amt)));
         5'b00001:          res = (I2 >> amt) | (I2 << (WIDTH - int'(amt)));
`else
         // amount-0 rotates complete immediately with I2 unchanged
         5'b00000: begin
            res      = I2;
            is_rot   = 1'b1;
            rot_left = 1'b1;
         end
         5'b00001: begin
            res    = I2;
            is_rot = 1'b1;
         end
`endif
         default:           res_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         O         <= '0;
         cout      <= 1'b0;
         bad_op    <= 1'b0;
`ifndef ITER_ALU_FAST_ROT_EN
         work      <= '0;
         cnt       <= '0;
         dir_left  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
`ifndef ITER_ALU_FAST_ROT_EN
                  if (is_rot && (amt != '0)) begin
                     work     <= I2;
                     cnt      <= amt;
                     dir_left <= rot_left;
                     state    <= ROT;
                  end else
`endif
                  begin
                     O         <= res;
                     cout      <= res_cout;
                     bad_op    <= res_bad;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
`ifndef ITER_ALU_FAST_ROT_EN
            ROT: begin
               work <= work_nxt;
               cnt  <= cnt - 1'b1;
               if (cnt == AW'(1)) begin
                  O         <= work_nxt;
                  cout      <= 1'b0;
                  bad_op    <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu: results, latency, back-pressure and reset abort.
module tb_iter_alu;
   localparam int WIDTH = 32;
   localparam int AW    = $clog2(WIDTH);

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] I1;
   logic [WIDTH-1:0] I2;
   logic [4:0]       Selector;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] O;
   logic             cout;
   logic             bad_op;

   int n_checks = 0;
   int n_errors = 0;

   iter_alu #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .I1(I1), .I2(I2), .Selector(Selector), .out_valid(out_valid),
      .out_ready(out_ready), .O(O), .cout(cout), .bad_op(bad_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int rot_lat(input int k);
`ifdef ITER_ALU_FAST_ROT_EN
      return 1;
`else
      return k + 1;
`endif
   endfunction

   task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_o, input logic exp_c,
                         input logic exp_b, input int exp_lat, input int hold);
      int n;
      check({tag, "_in_ready_idle"}, in_ready, 1);
      @(negedge clk);
      I1 = a; I2 = b; Selector = sel; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; I1 = ~a; I2 = ~b; Selector = 5'b10000;
      n = 1;
      while (!out_valid && n <= WIDTH + 4) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_O"}, O, exp_o);
      check({tag, "_cout"}, cout, exp_c);
      check({tag, "_bad_op"}, bad_op, exp_b);
      check({tag, "_in_ready_done"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_O"}, O, exp_o);
         check({tag, "_hold_in_ready"}, in_ready, 0);
      end
      @(negedge clk) out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_after_take"}, out_valid, 0);
      check({tag, "_in_ready_after_take"}, in_ready, 1);
   endtask

   initial begin
      bit seen;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      I1 = '0; I2 = '0; Selector = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_O", O, 0);
      check("rst_cout", cout, 0);
      check("rst_bad_op", bad_op, 0);
      check("rst_in_ready", in_ready, 0);
      // out_ready with nothing valid must not disturb anything
      out_ready = 1'b1;
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      run_op("add_wrap", 5'b10000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1, 0);
      run_op("add_plain", 5'b10000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 0, 0, 1, 0);
      run_op("bleu_eq", 5'b01000, 32'd5, 32'd5, 32'd1, 0, 0, 1, 0);
      run_op("bleu_gt", 5'b01000, 32'd6, 32'd5, 32'd0, 0, 0, 1, 0);
      run_op("bleu_uns", 5'b01000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 0, 0, 1, 0);
      run_op("not", 5'b00010, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hFFFF_0000, 0, 0, 1, 0);
      run_op("nori", 5'b00111, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0);
      run_op("nor_bp", 5'b10011, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0, 0, 0, 1, 3);
      run_op("rolv4", 5'b00000, 32'd4, 32'h8000_0001, 32'h0000_0018, 0, 0, rot_lat(4), 0);
      run_op("rorv1", 5'b00001, 32'd1, 32'h0000_0001, 32'h8000_0000, 0, 0, rot_lat(1), 0);
      run_op("rorv4", 5'b00001, 32'd4, 32'h1234_5678, 32'h8123_4567, 0, 0, rot_lat(4), 0);
      run_op("rorv_amt0", 5'b00001, 32'h20, 32'h1234_5678, 32'h1234_5678, 0, 0, 1, 0);
      run_op("rolv31", 5'b00000, 32'd31, 32'h0000_0001, 32'h8000_0000, 0, 0, rot_lat(31), 0);
      run_op("bad_sel", 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 1, 1, 0);

      // reset sampled four edges after accepting a rotate by 10
      @(negedge clk);
      I1 = 32'd10; I2 = 32'h0000_0001; Selector = 5'b00000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_O", O, 0);
      check("abort_in_ready", in_ready, 0);
      @(negedge clk) reset = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_stale", seen, 0);
      check("abort_idle", in_ready, 1);

      run_op("after_abort", 5'b10000, 32'd2, 32'd3, 32'd5, 0, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised, handshaked ALU for the datapath execute stage. Supports the full operation set (add, nor, nori, not, bleu, rolv, rorv) at configurable width. Logic ops finish in one cycle; rotates run iteratively, one bit per cycle, unless the fast-rotate build option is compiled in. Operands enter on a valid/ready handshake. The result is held on a valid/ready output until the consumer takes it.

## Interface
- WIDTH, 32: datapath width; power of two, ≥ 8.
- AW, $clog2(WIDTH): rotate-amount width (derived; do not override).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/selector valid.
- in_ready  output  1  block can accept; high only in IDLE and reset low.
- I1  input  WIDTH  operand 1; I1[AW-1:0] is rotate amount for rolv/rorv.
- I2  input  WIDTH  operand 2 (value rotated/negated).
- Selector  input  5  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- O  output  WIDTH  result.
- cout  output  1  carry out of add; 0 for other ops.
- bad_op  output  1  selector was not a defined opcode.

## Operation
- Opcodes:
  - 10000 add: O = I1+I2 mod 2^WIDTH, cout = carry.
  - 10011 nor and 00111 nori: O = ~(I1|I2).
  - 00010 not: O = ~I2.
  - 01000 bleu: O = (I1 ≤ I2, unsigned) ? 1 : 0, zero-extended.
  - 00000 rolv: O = I2 rotated left by I1[AW-1:0].
  - 00001 rorv: O = I2 rotated right by I1[AW-1:0].
- Undefined selector: O = 0, cout = 0, bad_op = 1. The op otherwise completes like a one-cycle op.
- States IDLE, ROT, DONE.
  - IDLE: in_ready = 1. Accept on in_valid & in_ready. Latch Selector, I2, and amount into internal registers.
  - IDLE → DONE: non-rotate op, or rotate with amount 0 (O = I2).
  - IDLE → ROT: rotate with amount k > 0. Load the counter with k.
  - ROT: each cycle rotate the working register by 1 bit in the latched direction and decrement the counter. When the counter reaches 1, that cycle's rotation is the last one and the next state is DONE.
  - DONE: out_valid = 1; O, cout and bad_op stable. On out_ready, go to IDLE.
- Operands are sampled only at acceptance; later changes on I1, I2 and Selector are ignored.
- No accept in the cycle DONE exits: in_ready rises the cycle after the handoff.

## Timing
- Reset (synchronous, dominant over all inputs):
  - state = IDLE.
  - out_valid = 0, O = 0, cout = 0, bad_op = 0.
  - in_ready = 0 while reset is high, 1 the cycle after reset deasserts.
- Latency, with acceptance at edge T:
  - Non-rotate op: out_valid high from T+1.
  - Rotate by k: out_valid high from T+1+k; maximum T+WIDTH.
- Throughput: one op per (latency + 1) cycles at best, since DONE→IDLE costs one cycle.
- Back-pressure: out_valid and all outputs hold indefinitely while out_ready is low.
- out_ready while out_valid is low has no effect.
- Reset asserted mid-ROT or in DONE abandons the op; no result is produced.

## Configuration
- ITER_ALU_FAST_ROT_EN:
  - Defined: rotates use a single-cycle barrel rotator, so the ROT state is unused and every op has latency 1.
  - Undefined (default): iterative 1-bit/cycle rotator as described above.
- Results are identical in both builds; only latency differs.

## Test plan
- add, I1=0xFFFFFFFF, I2=0x00000001, accept at T → O=0x00000000, cout=1, out_valid at T+1.
- bleu: (5,5) → O=1. (6,5) → O=0. (0x80000000, 0x7FFFFFFF) → O=0 (unsigned compare).
- rolv, I1=4, I2=0x80000001 → O=0x00000018 at T+5. rorv, I1=1, I2=0x00000001 → O=0x80000000 at T+2. Same two cases with ITER_ALU_FAST_ROT_EN defined → same results at T+1.
- rorv, I1=0x20 (amount bits = 0), I2=0x12345678 → O=0x12345678 at T+1. rolv amount 31 on 0x00000001 → O=0x80000000 at T+32.
- nor 0x0F0F0000/0x00000F0F → O=0xF0F0F0F0, out_ready held low 3 cycles. O must stay stable with out_valid=1. in_ready must stay 0 until the cycle after the handoff.
- Selector=11111 → bad_op=1, O=0. Separately, reset asserted mid-rotation (k=10, cycle T+4) → next cycle IDLE, out_valid=0, O=0, with no stale result emitted afterwards.
